// File: rtl/size_exploration_pkg.sv
// Shared types and constants for the size exploration harness.
//   mode_e    : arithmetic function of the compute unit
//   state_e   : sequencing FSM state
//   RES_W     : width of the result register / accumulator
//   cfg_legal : elaboration-time parameter legality check
package size_exploration_pkg;

  localparam int RES_W = 32;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_MULT = 2'd1,
    MODE_FMA  = 2'd2
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The full product must fit the result register without truncation.
  function automatic bit cfg_legal(input int width, input int channels, input int pipe);
    return (width >= 2) && (width <= 16) && (2 * width <= RES_W) &&
           (channels >= 1) && (channels <= 3) &&
           (pipe >= 0) && (pipe <= 3);
  endfunction

endpackage

// File: rtl/explore_unit.sv
// Compute unit under exploration: operand latch, ADD/MULT/FMA datapath,
// 32-bit accumulator with sticky overflow, and a PIPE-deep delay line.
//   clk, reset   : clock, synchronous active-high reset
//   ena          : global enable, low freezes every register
//   launch       : accepted start (already qualified by the FSM)
//   clr          : accepted accumulator clear (applied before launch)
//   a, b, c      : operands
//   res          : result, valid PIPE cycles after launch
//   ovf          : sticky accumulator carry-out (FMA only, else 0)
module explore_unit
  import size_exploration_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    PIPE     = 1,
  parameter mode_e MODE_SEL = MODE_FMA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             launch,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [RES_W-1:0] res,
  output logic             ovf
);

  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [RES_W-1:0] acc_q;
  logic             ovf_q;

  logic [RES_W-1:0] arith;
  logic [RES_W-1:0] fma_term;
  logic [RES_W-1:0] acc_base;
  logic [RES_W:0]   acc_sum;
  logic [RES_W-1:0] stage0;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    arith    = '0;
    fma_term = RES_W'(a) * RES_W'(b) + RES_W'(c);
    acc_base = clr ? '0 : acc_q;
    acc_sum  = (RES_W + 1)'(acc_base) + (RES_W + 1)'(fma_term);
    case (MODE_SEL)
      MODE_ADD:  arith = RES_W'(a_q) + RES_W'(b_q) + RES_W'(c_q);
      MODE_MULT: arith = RES_W'(a_q) * RES_W'(b_q);
      default:   arith = acc_q;
    endcase
    stage0 = arith;
  end

  // The accumulator updates on the launch edge from the live operands, so
  // in FMA mode acc_q itself plays the role of the operand latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (ena) begin
      if (launch) begin
        a_q   <= a;
        b_q   <= b;
        c_q   <= c;
        acc_q <= acc_sum[RES_W-1:0];
      end else if (clr) begin
        acc_q <= '0;
      end
      ovf_q <= (ovf_q & ~clr) | (launch & acc_sum[RES_W]);
    end
  end

  assign ovf = (MODE_SEL == MODE_FMA) ? ovf_q : 1'b0;

  if (PIPE == 0) begin : g_no_pipe
    assign res = stage0;
  end else begin : g_pipe
    logic [RES_W-1:0] dly_q [PIPE];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < PIPE; k++) dly_q[k] <= '0;
      end else if (ena) begin
        dly_q[0] <= stage0;
        for (int k = 1; k < PIPE; k++) dly_q[k] <= dly_q[k-1];
      end
    end

    assign res = dly_q[PIPE-1];
  end

endmodule

// File: rtl/size_exploration_harness.sv
// Pin-limited exploration wrapper: serially loads up to three operands,
// launches one operation on the compute unit, and exposes the 32-bit result
// one byte at a time.
//   clk, reset : clock, synchronous active-high reset
//   ena        : global enable, low freezes all state
//   ser_in     : one serial operand bit per channel, MSB first
//   shift      : shift one bit into every operand register (IDLE only)
//   start      : launch one operation (IDLE only)
//   acc_clr    : clear accumulator, applied before a same-cycle start
//   sel        : result byte select, 0 = bits 7:0 ... 3 = bits 31:24
//   dout       : selected result byte (combinational)
//   busy       : operation in flight
//   done       : one-cycle pulse when the result register updates
//   ovf        : sticky accumulator overflow (FMA only)
module size_exploration_harness
  import size_exploration_pkg::*;
#(
  parameter int    WIDTH    = 8,
  parameter int    CHANNELS = 2,
  parameter string MODE     = "FMA",
  parameter int    PIPE     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic [CHANNELS-1:0] ser_in,
  input  logic                shift,
  input  logic                start,
  input  logic                acc_clr,
  input  logic [1:0]          sel,
  output logic [7:0]          dout,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  localparam mode_e MODE_SEL = (MODE == "ADD")  ? MODE_ADD  :
                               (MODE == "MULT") ? MODE_MULT : MODE_FMA;

  if (!cfg_legal(WIDTH, CHANNELS, PIPE) ||
      !(MODE == "ADD" || MODE == "MULT" || MODE == "FMA")) begin : g_illegal_cfg
    $error("size_exploration_harness: illegal parameter combination");
  end

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [RES_W-1:0] result_q;
  logic [WIDTH-1:0] op_q [CHANNELS];
  logic [WIDTH-1:0] a, b, c;
  logic [RES_W-1:0] unit_res;
  logic             idle;
  logic             launch;
  logic             clr;

  assign idle   = (state_q == ST_IDLE);
  assign launch = ena & idle & start;
  assign clr    = ena & idle & acc_clr;

  assign a = op_q[0];
  if (CHANNELS == 1) begin : g_b_alias
    assign b = op_q[0];
  end else begin : g_b_chan
    assign b = op_q[1];
  end
  if (CHANNELS == 3) begin : g_c_chan
    assign c = op_q[2];
  end else begin : g_c_zero
    assign c = '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      done     <= 1'b0;
      // NOTE: the operand array is a handful of flops, not a RAM, and its
      // contents are observable, so it is reset along with the control state.
      for (int i = 0; i < CHANNELS; i++) op_q[i] <= '0;
    end else if (ena) begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'(PIPE);
          end else if (shift) begin
            for (int i = 0; i < CHANNELS; i++)
              op_q[i] <= {op_q[i][WIDTH-2:0], ser_in[i]};
          end
        end
        default: begin
          if (cnt_q == 2'd0) begin
            result_q <= unit_res;
            done     <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
      endcase
    end
  end

  explore_unit #(
    .WIDTH    (WIDTH),
    .PIPE     (PIPE),
    .MODE_SEL (MODE_SEL)
  ) u_unit (
    .clk    (clk),
    .reset  (reset),
    .ena    (ena),
    .launch (launch),
    .clr    (clr),
    .a      (a),
    .b      (b),
    .c      (c),
    .res    (unit_res),
    .ovf    (ovf)
  );

  assign busy = ~idle;
  assign dout = result_q[{sel, 3'b000} +: 8];

endmodule

// File: tb/tb_size_exploration_harness.sv
// Self-checking bench: four harness configurations share clock, reset, ena
// and sel; the control/serial stimulus is steered to one of them by 'who'.
//   who 0: MULT, WIDTH 8,  CHANNELS 2, PIPE 2
//   who 1: FMA,  WIDTH 8,  CHANNELS 2, PIPE 1
//   who 2: ADD,  WIDTH 8,  CHANNELS 3, PIPE 0
//   who 3: FMA,  WIDTH 16, CHANNELS 2, PIPE 1
module tb_size_exploration_harness;

  logic       clk = 1'b0;
  logic       reset, ena, shift, start, acc_clr;
  logic [2:0] ser;
  logic [1:0] sel;
  int         who;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic [7:0] m_dout, f_dout, a_dout, w_dout;
  logic       m_busy, f_busy, a_busy, w_busy;
  logic       m_done, f_done, a_done, w_done;
  logic       m_ovf,  f_ovf,  a_ovf,  w_ovf;

  size_exploration_harness #(.WIDTH(8), .CHANNELS(2), .MODE("MULT"), .PIPE(2)) u_mul (
    .clk(clk), .reset(reset), .ena(ena), .ser_in(ser[1:0]),
    .shift(shift & (who == 0)), .start(start & (who == 0)), .acc_clr(acc_clr & (who == 0)),
    .sel(sel), .dout(m_dout), .busy(m_busy), .done(m_done), .ovf(m_ovf));

  size_exploration_harness #(.WIDTH(8), .CHANNELS(2), .MODE("FMA"), .PIPE(1)) u_fma8 (
    .clk(clk), .reset(reset), .ena(ena), .ser_in(ser[1:0]),
    .shift(shift & (who == 1)), .start(start & (who == 1)), .acc_clr(acc_clr & (who == 1)),
    .sel(sel), .dout(f_dout), .busy(f_busy), .done(f_done), .ovf(f_ovf));

  size_exploration_harness #(.WIDTH(8), .CHANNELS(3), .MODE("ADD"), .PIPE(0)) u_add (
    .clk(clk), .reset(reset), .ena(ena), .ser_in(ser),
    .shift(shift & (who == 2)), .start(start & (who == 2)), .acc_clr(acc_clr & (who == 2)),
    .sel(sel), .dout(a_dout), .busy(a_busy), .done(a_done), .ovf(a_ovf));

  size_exploration_harness #(.WIDTH(16), .CHANNELS(2), .MODE("FMA"), .PIPE(1)) u_fma16 (
    .clk(clk), .reset(reset), .ena(ena), .ser_in(ser[1:0]),
    .shift(shift & (who == 3)), .start(start & (who == 3)), .acc_clr(acc_clr & (who == 3)),
    .sel(sel), .dout(w_dout), .busy(w_busy), .done(w_done), .ovf(w_ovf));

  logic [7:0] cur_dout;
  logic       cur_busy, cur_done, cur_ovf;

  always_comb begin
    cur_dout = m_dout;
    cur_busy = m_busy;
    cur_done = m_done;
    cur_ovf  = m_ovf;
    case (who)
      1: begin cur_dout = f_dout; cur_busy = f_busy; cur_done = f_done; cur_ovf = f_ovf; end
      2: begin cur_dout = a_dout; cur_busy = a_busy; cur_done = a_done; cur_ovf = a_ovf; end
      3: begin cur_dout = w_dout; cur_busy = w_busy; cur_done = w_done; cur_ovf = w_ovf; end
      default: ;
    endcase
  end

  function automatic int pipe_of(input int w);
    case (w)
      0:       return 2;
      2:       return 0;
      default: return 1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (dut %0d): got 0x%0h expected 0x%0h", name, who, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input int width);
    for (int i = width - 1; i >= 0; i--) begin
      ser   = {c[i], b[i], a[i]};
      shift = 1'b1;
      tick();
    end
    shift = 1'b0;
    ser   = 3'b000;
  endtask

  // Launches one operation and returns the number of edges after the start
  // edge until done is seen (bounded).
  task automatic run_op(output int edges);
    start = 1'b1;
    tick();
    start   = 1'b0;
    shift   = 1'b0;
    acc_clr = 1'b0;
    check("busy_after_start", 32'(cur_busy), 32'd1);
    edges = 0;
    while (!cur_done && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic read32(output logic [31:0] v);
    v = '0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      v[8*s +: 8] = cur_dout;
    end
    sel = 2'd0;
  endtask

  typedef struct {
    int          who;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    int          width;
    bit          clr;
    logic [31:0] exp_res;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          edges;
    int          dones;
    logic [31:0] r;
    logic [31:0] e;

    vecs[0] = '{0, 16'h000F, 16'h0011, 16'h0000,  8, 1'b0, 32'h0000_00FF, 1'b0};
    vecs[1] = '{0, 16'h00FF, 16'h00FF, 16'h0000,  8, 1'b0, 32'h0000_FE01, 1'b0};
    vecs[2] = '{1, 16'd200,  16'd200,  16'h0000,  8, 1'b1, 32'd40000,     1'b0};
    vecs[3] = '{1, 16'd200,  16'd200,  16'h0000,  8, 1'b0, 32'd80000,     1'b0};
    vecs[4] = '{2, 16'h00FF, 16'h00FF, 16'h00FF,  8, 1'b0, 32'h0000_02FD, 1'b0};
    vecs[5] = '{2, 16'h0001, 16'h0002, 16'h0003,  8, 1'b0, 32'h0000_0006, 1'b0};
    vecs[6] = '{3, 16'hFFFF, 16'hFFFF, 16'h0000, 16, 1'b1, 32'hFFFE_0001, 1'b0};
    vecs[7] = '{3, 16'hFFFF, 16'hFFFF, 16'h0000, 16, 1'b0, 32'hFFFC_0002, 1'b1};

    reset = 1'b1; ena = 1'b1; shift = 1'b0; start = 1'b0; acc_clr = 1'b0;
    ser = 3'b000; sel = 2'd0; who = 0;
    tick();
    tick();

    // Reset state, every configuration, every byte lane.
    for (int d = 0; d < 4; d++) begin
      who = d;
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        #1;
        check("reset_dout", 32'(cur_dout), 32'h0);
      end
      check("reset_busy", 32'(cur_busy), 32'd0);
      check("reset_done", 32'(cur_done), 32'd0);
      check("reset_ovf",  32'(cur_ovf),  32'd0);
    end
    sel   = 2'd0;
    reset = 1'b0;
    tick();

    // Table of single operations: latency, result bytes, ovf, done width.
    for (int k = 0; k < 8; k++) begin
      who = vecs[k].who;
      load(vecs[k].a, vecs[k].b, vecs[k].c, vecs[k].width);
      acc_clr = vecs[k].clr;
      run_op(edges);
      check("latency", 32'(edges), 32'(pipe_of(who) + 1));
      check("busy_at_done", 32'(cur_busy), 32'd0);
      e = vecs[k].exp_res;
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        #1;
        check("result_byte", 32'(cur_dout), 32'(e[8*s +: 8]));
      end
      sel = 2'd0;
      check("ovf", 32'(cur_ovf), 32'(vecs[k].exp_ovf));
      tick();
      check("done_one_cycle", 32'(cur_done), 32'd0);
    end

    // ADD: shift in the same cycle as start is dropped.
    who = 2;
    load(16'h1, 16'h2, 16'h3, 8);
    ser   = 3'b111;
    shift = 1'b1;
    run_op(edges);
    read32(r);
    check("start_shift_result", r, 32'd6);
    run_op(edges);
    read32(r);
    check("start_shift_operands_kept", r, 32'd6);

    // MULT: start/shift/acc_clr during RUN are ignored, only one done.
    who = 0;
    load(16'h3, 16'h5, 16'h0, 8);
    start = 1'b1;
    tick();
    ser = 3'b111; shift = 1'b1; acc_clr = 1'b1;
    dones = 0;
    repeat (3) begin
      tick();
      dones += 32'(cur_done);
    end
    start = 1'b0; shift = 1'b0; acc_clr = 1'b0; ser = 3'b000;
    repeat (5) begin
      tick();
      dones += 32'(cur_done);
    end
    check("run_ignore_done_count", 32'(dones), 32'd1);
    read32(r);
    check("run_ignore_result", r, 32'd15);
    run_op(edges);
    read32(r);
    check("run_ignore_operands_kept", r, 32'd15);

    // FMA8: acc_clr during RUN does not clear the accumulator.
    who = 1;
    load(16'h1, 16'h1, 16'h0, 8);
    start = 1'b1;
    tick();
    start   = 1'b0;
    acc_clr = 1'b1;
    repeat (2) tick();
    acc_clr = 1'b0;
    check("acc_clr_run_done", 32'(cur_done), 32'd1);
    read32(r);
    check("acc_clr_run_ignored", r, 32'd80001);

    // FMA16: ovf is sticky across a non-overflowing op, cleared by acc_clr.
    who = 3;
    load(16'h0, 16'h0, 16'h0, 16);
    run_op(edges);
    read32(r);
    check("ovf_sticky_result", r, 32'hFFFC_0002);
    check("ovf_sticky", 32'(cur_ovf), 32'd1);
    tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("ovf_cleared", 32'(cur_ovf), 32'd0);

    // FMA16: ena low for 5 cycles mid-RUN stretches latency by 5.
    load(16'h2, 16'h3, 16'h0, 16);
    start = 1'b1;
    tick();
    start = 1'b0;
    ena   = 1'b0;
    repeat (5) tick();
    check("freeze_busy", 32'(cur_busy), 32'd1);
    check("freeze_no_done", 32'(cur_done), 32'd0);
    ena   = 1'b1;
    edges = 5;
    while (!cur_done && edges < 40) begin
      tick();
      edges++;
    end
    check("freeze_latency", 32'(edges), 32'd7);
    read32(r);
    check("freeze_result", r, 32'd6);

    // MULT: reset during RUN aborts with no done pulse.
    who = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dones = 0;
    repeat (6) begin
      tick();
      dones += 32'(cur_done);
    end
    check("abort_no_done", 32'(dones), 32'd0);
    check("abort_busy", 32'(cur_busy), 32'd0);
    read32(r);
    check("abort_dout", r, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
